// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for a shared multicycle MIPS datapath. The datapath
// has one memory, one ALU and an instruction register. The FSM steps each
// instruction through fetch, decode, execute, memory and writeback. It drives
// the datapath mux selects and write strobes, and it issues an alu_op to the
// existing ALU decoder. Memory accesses wait on mem_ready, so a slow memory can
// stall FETCH, MEMRD and MEMWR for any number of cycles.
//
// Supported instructions: R-type, lw, sw, beq, addi.
// j is supported only when the build defines MULTICYCLE_JUMP_EN. Without that
// macro, opcode 6'b000010 is treated as illegal and pc_src never equals 2'b10.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   opcode      in   [5:0] instruction[31:26] from the instruction register
//   mem_ready   in   memory completes the requested access this cycle
//   mem_req     out  memory access requested
//   iord        out  memory address select: 0 = PC, 1 = ALUOut
//   mem_write   out  memory write (sw)
//   ir_write    out  load the instruction register
//   pc_write    out  unconditional PC update
//   branch      out  PC update if the ALU zero flag is set
//   pc_src      out  [1:0] 00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a   out  0 = PC, 1 = register A
//   alu_src_b   out  [1:0] 00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
//   alu_op      out  [1:0] 00 add, 01 sub, 10 use funct field
//   reg_dst     out  register write address: 1 = rd, 0 = rt
//   mem_to_reg  out  register write data: 1 = memory data, 0 = ALUOut
//   reg_write   out  register file write enable
//   instr_done  out  one-cycle pulse in the final cycle of each instruction
//   illegal_op  out  one-cycle pulse in DECODE for an unsupported opcode
//   state       out  [3:0] current state encoding (debug)
//
// All outputs are combinational from the state register and mem_ready. While
// rst is high, every strobe is held at 0 and every select shows its FETCH
// value. This keeps the datapath from writing anything while the core is in
// reset.
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  state_e state_q;
  state_e state_d;

  // State register: reset always wins, including in the middle of a memory stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // The state register may still hold X before the first reset edge, so the
  // debug output shows FETCH whenever rst is high.
  assign state = rst ? 4'd0 : state_q;

  // Next-state and Moore output decode, gated by mem_ready in the memory states.
  always_comb begin
    state_d    = S_FETCH;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    if (rst) begin
      // Strobes stay low. Selects show their FETCH values.
      alu_src_b = 2'b01;
      state_d   = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          // PC + 4 is computed every fetch cycle. It is only committed
          // (together with the IR load) in the cycle the memory answers.
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) begin
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end

        S_DECODE: begin
          // Precompute the branch target PC + (imm << 2) into ALUOut.
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEXEC;
`ifdef MULTICYCLE_JUMP_EN
            OP_J:         state_d = S_JUMP;
`endif
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end

        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          // The IR does not change after fetch, so opcode still identifies
          // lw or sw here. Anything else cannot occur; it falls back to FETCH.
          if (opcode == OP_LW) begin
            state_d = S_MEMRD;
          end else if (opcode == OP_SW) begin
            state_d = S_MEMWR;
          end else begin
            state_d = S_FETCH;
          end
        end

        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            state_d = S_MEMWB;
          end else begin
            state_d = S_MEMRD;
          end
        end

        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_MEMWR: begin
          // mem_write stays high for the whole stall. The store finishes
          // in the cycle the memory accepts it.
          mem_req    = 1'b1;
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_MEMWR;
          end
        end

        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_ALUWB;
        end

        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_BRANCH: begin
          // Compute A - B to get the zero flag. The target precomputed in
          // DECODE sits in ALUOut.
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_src     = 2'b01;
          branch     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_ADDIEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_ADDIWB;
        end

        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

`ifdef MULTICYCLE_JUMP_EN
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
`endif

        default: begin
          // Unreachable encodings (and JUMP when jumps are not built in)
          // drive nothing and recover to FETCH.
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b100011;
  logic       mem_ready = 1'b1;
  logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  // Observed outputs, packed in this order:
  // {mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_src_a,
  //  alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, state}
  logic [21:0] obs;
  assign obs = {mem_req, iord, mem_write, ir_write, pc_write, branch, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, state};

  //                          mrq   iord  mwr   irw   pcw   br    pcs    asa   asb    aop    rd    m2r   rw    done  ill   state
  localparam logic [21:0] E_RST    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
  localparam logic [21:0] E_FET_S  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
  localparam logic [21:0] E_FET_R  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
  localparam logic [21:0] E_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
  localparam logic [21:0] E_DEC_IL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1};
  localparam logic [21:0] E_MADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
  localparam logic [21:0] E_MRD    = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
  localparam logic [21:0] E_MWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4};
  localparam logic [21:0] E_MWR_S  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5};
  localparam logic [21:0] E_MWR_R  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5};
  localparam logic [21:0] E_EXE    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6};
  localparam logic [21:0] E_AWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7};
  localparam logic [21:0] E_BR     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8};
  localparam logic [21:0] E_AEX    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9};
  localparam logic [21:0] E_AWB2   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd10};
  localparam logic [21:0] E_JMP    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd11};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] exp_q[$];
  int          idx_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic void add(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [21:0] exp);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Scoreboard checker: compare each queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] e;
      int          k;
      e = exp_q.pop_front();
      k = idx_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL vec%0d: got %b required %b", k, obs, e);
      end
    end
  end

  task automatic count_cycles(input logic [5:0] op, input int exp, input string nm);
    int n;
    int pulses;
    @(posedge clk); #1; rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1; rst = 1'b0; opcode = op;
    n = 0; pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (instr_done === 1'b1) begin
        pulses++;
        if (n == 0) n = i;
      end
    end
    n_cmp++;
    if (n != exp) begin
      n_fail++;
      $display("FAIL cycles_%s: got %0d required %0d", nm, n, exp);
    end
    // 12 cycles after the reset release, every instruction has completed at least twice.
    n_cmp++;
    if (pulses < 2) begin
      n_fail++;
      $display("FAIL pulses_%s: got %0d required >=2", nm, pulses);
    end
  endtask

  initial begin
    // Reset
    add(1'b1, OP_LW, 1'b1, E_RST);
    add(1'b1, OP_LW, 1'b0, E_RST);
    // lw, no stalls: states 0,1,2,3,4, then 0
    add(1'b0, OP_LW, 1'b1, E_FET_R);
    add(1'b0, OP_LW, 1'b1, E_DEC);
    add(1'b0, OP_LW, 1'b1, E_MADR);
    add(1'b0, OP_LW, 1'b1, E_MRD);
    add(1'b0, OP_LW, 1'b1, E_MWB);
    // sw with 3 stall cycles in MEMWR
    add(1'b0, OP_SW, 1'b1, E_FET_R);
    add(1'b0, OP_SW, 1'b0, E_DEC);
    add(1'b0, OP_SW, 1'b1, E_MADR);
    add(1'b0, OP_SW, 1'b0, E_MWR_S);
    add(1'b0, OP_SW, 1'b0, E_MWR_S);
    add(1'b0, OP_SW, 1'b0, E_MWR_S);
    add(1'b0, OP_SW, 1'b1, E_MWR_R);
    // R-type then beq back to back (mem_ready is ignored in EXECUTE)
    add(1'b0, OP_R,   1'b1, E_FET_R);
    add(1'b0, OP_R,   1'b1, E_DEC);
    add(1'b0, OP_R,   1'b0, E_EXE);
    add(1'b0, OP_R,   1'b1, E_AWB);
    add(1'b0, OP_BEQ, 1'b1, E_FET_R);
    add(1'b0, OP_BEQ, 1'b1, E_DEC);
    add(1'b0, OP_BEQ, 1'b1, E_BR);
    // FETCH stall of 2 cycles, then addi
    add(1'b0, OP_ADI, 1'b0, E_FET_S);
    add(1'b0, OP_ADI, 1'b0, E_FET_S);
    add(1'b0, OP_ADI, 1'b1, E_FET_R);
    add(1'b0, OP_ADI, 1'b1, E_DEC);
    add(1'b0, OP_ADI, 1'b1, E_AEX);
    add(1'b0, OP_ADI, 1'b1, E_AWB2);
    // Illegal opcode
    add(1'b0, OP_BAD, 1'b1, E_FET_R);
    add(1'b0, OP_BAD, 1'b1, E_DEC_IL);
    // j: legal only when the jump option is built
    add(1'b0, OP_J, 1'b1, E_FET_R);
`ifdef MULTICYCLE_JUMP_EN
    add(1'b0, OP_J, 1'b1, E_DEC);
    add(1'b0, OP_J, 1'b1, E_JMP);
`else
    add(1'b0, OP_J, 1'b1, E_DEC_IL);
`endif
    // Reset during a MEMRD stall
    add(1'b0, OP_LW, 1'b1, E_FET_R);
    add(1'b0, OP_LW, 1'b1, E_DEC);
    add(1'b0, OP_LW, 1'b1, E_MADR);
    add(1'b0, OP_LW, 1'b0, E_MRD);
    add(1'b1, OP_LW, 1'b0, E_RST);
    add(1'b0, OP_LW, 1'b1, E_FET_R);
    // Reset in FETCH with mem_ready high blocks ir_write and pc_write
    add(1'b1, OP_LW, 1'b1, E_RST);
    add(1'b0, OP_LW, 1'b0, E_FET_S);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      exp_q.push_back(vecs[i].exp);
      idx_q.push_back(i);
    end
    @(negedge clk);
    #1;

    // Cycle counts with mem_ready tied to 1
    count_cycles(OP_LW,  5, "lw");
    count_cycles(OP_SW,  4, "sw");
    count_cycles(OP_R,   4, "rtype");
    count_cycles(OP_ADI, 4, "addi");
    count_cycles(OP_BEQ, 3, "beq");
    count_cycles(OP_BAD, 2, "illegal");
`ifdef MULTICYCLE_JUMP_EN
    count_cycles(OP_J,   3, "j");
`else
    count_cycles(OP_J,   2, "j");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences the shared multicycle MIPS datapath (single memory, single ALU, instruction register) through fetch, decode, execute, memory and writeback steps. It supports R-type, lw, sw, beq and addi, plus j when configured. It drives the datapath mux selects and write strobes and issues an `alu_op` to the existing ALU decoder. It also handshakes with a memory that may stall.

## Interface
Parameters: none (opcodes fixed: R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, addi 6'b001000, j 6'b000010).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  instruction[31:26] from instruction register
- `mem_ready`  in  1  memory completes access this cycle
- `mem_req`  out  1  memory access requested
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write (sw)
- `ir_write`  out  1  load instruction register
- `pc_write`  out  1  unconditional PC update
- `branch`  out  1  PC update if ALU zero
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = register B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- `alu_op`  out  2  to ALU decoder (00 add, 01 sub, 10 funct)
- `reg_dst`  out  1  1 = rd, 0 = rt
- `mem_to_reg`  out  1  1 = memory data, 0 = ALUOut
- `reg_write`  out  1  register file write enable
- `instr_done`  out  1  one-cycle pulse in final cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE on unsupported opcode
- `state`  out  4  current state encoding (debug)

## Operation
- State encoding:
  - FETCH = 0
  - DECODE = 1
  - MEMADR = 2
  - MEMRD = 3
  - MEMWB = 4
  - MEMWR = 5
  - EXECUTE = 6
  - ALUWB = 7
  - BRANCH = 8
  - ADDIEXEC = 9
  - ADDIWB = 10
  - JUMP = 11
  - Codes 12–15 are unreachable; if ever entered, the next state is FETCH.
- Outputs are a function of `state`, gated by `mem_ready` where noted. Any output not listed for a state is 0.
- FETCH: `mem_req` = 1, `iord` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `alu_op` = 00, `pc_src` = 00. `ir_write` and `pc_write` equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE: `alu_src_a` = 0, `alu_src_b` = 11, `alu_op` = 00 (branch target precompute). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXECUTE
  - beq → BRANCH
  - addi → ADDIEXEC
  - j → JUMP (only with JUMP_EN)
  - anything else → FETCH, with `illegal_op` = 1 and `instr_done` = 1
- MEMADR: `alu_src_a` = 1, `alu_src_b` = 10. Next state is MEMRD for lw or MEMWR for sw; `opcode` is stable because IR is unchanged.
- MEMRD: `mem_req` = 1, `iord` = 1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `reg_write` = 1, `mem_to_reg` = 1, `reg_dst` = 0, `instr_done` = 1. Next state FETCH.
- MEMWR: `mem_req` = 1, `iord` = 1, `mem_write` = 1 held for the whole stall. `instr_done` equals `mem_ready`. Leave to FETCH on `mem_ready`.
- EXECUTE: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 10. Next state ALUWB.
- ALUWB: `reg_write` = 1, `reg_dst` = 1, `mem_to_reg` = 0, `instr_done` = 1. Next state FETCH.
- BRANCH: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 01, `pc_src` = 01, `branch` = 1, `instr_done` = 1. Next state FETCH.
- ADDIEXEC: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00. Next state ADDIWB.
- ADDIWB: `reg_write` = 1, `reg_dst` = 0, `mem_to_reg` = 0, `instr_done` = 1. Next state FETCH.
- JUMP: `pc_write` = 1, `pc_src` = 10, `instr_done` = 1. Next state FETCH.

## Timing
- The state register updates on the rising edge of `clk`. All outputs are combinational from `state` and `mem_ready`; there is no added output latency.
- Reset:
  - `rst` high at an edge loads FETCH, including when a memory access is mid-stall.
  - While `rst` is high, `mem_req`, `mem_write`, `ir_write`, `pc_write`, `branch`, `reg_write`, `instr_done` and `illegal_op` are forced to 0.
  - Select outputs take their FETCH values: `iord` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `alu_op` = 00, `pc_src` = 00, `reg_dst` = 0, `mem_to_reg` = 0, `state` = 0.
- Cycle counts with `mem_ready` tied to 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
  - Each stall cycle (`mem_ready` = 0 in FETCH, MEMRD or MEMWR) adds 1.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `opcode` is sampled only in DECODE and MEMADR.

## Configuration
- `MULTICYCLE_JUMP_EN` defined: the JUMP state exists and opcode 6'b000010 decodes to JUMP.
- `MULTICYCLE_JUMP_EN` undefined: 6'b000010 is illegal (DECODE → FETCH with an `illegal_op` pulse), and `pc_src` never equals 10.

## Test plan
- Reset, then `mem_ready` = 1 with an lw opcode: state sequence 0,1,2,3,4,0. `reg_write` = 1 and `mem_to_reg` = 1 only in state 4. `instr_done` pulses once, 5 cycles after reset release.
- sw with `mem_ready` held low for 3 cycles in MEMWR: `mem_write` = 1 for 4 consecutive cycles, `iord` = 1, `instr_done` only in the 4th MEMWR cycle. `reg_write` never asserts.
- R-type then beq back-to-back: `alu_op` is 10 in EXECUTE and 01 in BRANCH. `branch` = 1 and `pc_src` = 01 only in BRANCH. Total 7 cycles.
- FETCH stall of 2 cycles: `ir_write` and `pc_write` stay 0 for 2 cycles, then go to 1 for exactly 1 cycle, followed by state 1.
- Opcode 6'b111111: `illegal_op` and `instr_done` pulse in DECODE, then return to FETCH. With the macro undefined, 6'b000010 behaves identically; with it defined, 6'b000010 goes to state 11 with `pc_write` = 1 and `pc_src` = 10.
- `rst` asserted during a MEMRD stall: next state is 0 and all strobes read 0 while `rst` is high.
